instr_encoder: RTL and testbench

- Produces 32-bit MIPS instruction words from field-level requests. It does the inverse job of the instruction decoder.
- Writes each encoded word to instruction memory at an auto-incrementing word address.
- Used by the program loader and by self-test benches to fill instruction memory before the core runs.
- A 2-entry output buffer decouples the request side from memory backpressure.

---
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder.sv | 167 ++++++++++++++++
 tb/tb_instr_encoder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request and write-port bundle for the MIPS instruction encoder.
// master = program loader / bench side, slave = encoder side.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [3:0]        req_op_i;
  logic [4:0]        req_rs_i;
  logic [4:0]        req_rt_i;
  logic [4:0]        req_rd_i;
  logic [15:0]       req_imm_i;
  logic [25:0]       req_target_i;
  logic              wr_valid_o;
  logic              wr_ready_i;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic              err_o;
  logic [15:0]       wr_count_o;

  modport master (
    output start_i, req_valid_i, req_op_i, req_rs_i, req_rt_i, req_rd_i,
           req_imm_i, req_target_i, wr_ready_i,
    input  req_ready_o, wr_valid_o, wr_addr_o, wr_data_o, err_o, wr_count_o
  );

  modport slave (
    input  start_i, req_valid_i, req_op_i, req_rs_i, req_rt_i, req_rd_i,
           req_imm_i, req_target_i, wr_ready_i,
    output req_ready_o, wr_valid_o, wr_addr_o, wr_data_o, err_o, wr_count_o
  );
endinterface

// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns field-level requests into 32-bit words and
// queues them, with an auto-incrementing word address, in a 2-entry buffer
// toward instruction memory. The buffer is a shift structure so the head
// entry always lives in one register and drives the write port directly.
module instr_encoder #(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input logic            clk_i,
  input logic            rst_i,
  instr_encoder_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_SLT  = 4'd4,  OP_LW   = 4'd5,  OP_SW   = 4'd6,  OP_BEQ  = 4'd7,
    OP_BNE  = 4'd8,  OP_ADDI = 4'd9,  OP_ANDI = 4'd10, OP_J    = 4'd11,
    OP_JAL  = 4'd12, OP_JR   = 4'd13, OP_NOP  = 4'd14, OP_ILL  = 4'd15
  } op_e;

  localparam int                EW     = ADDR_W + 32;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

  // Field-level encoding; shamt is always zero, unused fields are ignored.
  function automatic logic [31:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] tgt
  );
    logic [31:0] w;
    case (op_e'(op))
      OP_ADD:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      OP_SUB:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      OP_AND:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      OP_OR:   w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      OP_SLT:  w = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      OP_LW:   w = {6'b100011, rs, rt, imm};
      OP_SW:   w = {6'b101011, rs, rt, imm};
      OP_BEQ:  w = {6'b000100, rs, rt, imm};
      OP_BNE:  w = {6'b000101, rs, rt, imm};
      OP_ADDI: w = {6'b001000, rs, rt, imm};
      OP_ANDI: w = {6'b001100, rs, rt, imm};
      OP_J:    w = {6'b000010, tgt};
      OP_JAL:  w = {6'b000011, tgt};
      OP_JR:   w = {6'b000000, rs, 15'b000000000000000, 6'b001000};
      OP_NOP:  w = 32'h0000_0000;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic [1:0]        cnt_q,   cnt_d;
  logic [EW-1:0]     head_q,  head_d;
  logic [EW-1:0]     tail_q,  tail_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              err_q,   err_d;
  logic [15:0]       wrcnt_q, wrcnt_d;

  logic          req_ready_s;
  logic          accept_s;
  logic          legal_s;
  logic          push_s;
  logic          pop_s;
  logic [EW-1:0] new_entry_s;

  // Ready never looks at wr_ready_i, so there is no valid-to-ready loop.
  assign req_ready_s = !rst_i && !bus.start_i && (cnt_q != 2'd2);
  assign accept_s    = bus.req_valid_i && req_ready_s;
  assign legal_s     = (bus.req_op_i != OP_ILL);
  assign push_s      = accept_s && legal_s;
  assign pop_s       = (cnt_q != 2'd0) && bus.wr_ready_i && !bus.start_i;
  assign new_entry_s = {addr_q, encode(bus.req_op_i, bus.req_rs_i, bus.req_rt_i,
                                       bus.req_rd_i, bus.req_imm_i, bus.req_target_i)};

  // Next-state for buffer, address counter, error flag and handshake count.
  always_comb begin
    cnt_d   = cnt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    addr_d  = addr_q;
    err_d   = err_q;
    wrcnt_d = wrcnt_q;

    if (pop_s) begin
      wrcnt_d = wrcnt_q + 16'd1;
    end else begin
      wrcnt_d = wrcnt_q;
    end

    if (bus.start_i) begin
      // Restart wins over any push or pop this cycle.
      cnt_d  = 2'd0;
      addr_d = BASE_A;
      err_d  = 1'b0;
    end else begin
      if (accept_s && !legal_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end

      if (push_s) begin
        addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        addr_d = addr_q;
      end

      case ({push_s, pop_s})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_d = new_entry_s;
          end else begin
            tail_d = new_entry_s;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          // Only reachable with one entry held (ready is low when full).
          if (cnt_q == 2'd1) begin
            head_d = new_entry_s;
          end else begin
            head_d = tail_q;
            tail_d = new_entry_s;
          end
          cnt_d = cnt_q;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // State registers; reset discards buffered words immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= 2'd0;
      head_q  <= {EW{1'b0}};
      tail_q  <= {EW{1'b0}};
      addr_q  <= BASE_A;
      err_q   <= 1'b0;
      wrcnt_q <= 16'd0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      wrcnt_q <= wrcnt_d;
    end
  end

  assign bus.req_ready_o = req_ready_s;
  assign bus.wr_valid_o  = (cnt_q != 2'd0);
  assign bus.wr_addr_o   = head_q[EW-1:32];
  assign bus.wr_data_o   = head_q[31:0];
  assign bus.err_o       = err_q;
  assign bus.wr_count_o  = wrcnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver pushes expected words from a
// field-arithmetic reference model, a negedge monitor pops and compares.
module tb_instr_encoder;
  localparam int AW   = 3;
  localparam int BASE = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(AW)) bus ();
  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  ent_t sb[$];
  ent_t got[$];
  int   addr_m = BASE;
  bit   err_m  = 1'b0;
  int   cnt_m  = 0;

  // stimulus state
  bit          v = 1'b0, st = 1'b0, wrr = 1'b1;
  logic [3:0]  f_op = 4'd14;
  logic [4:0]  f_rs = 5'd0, f_rt = 5'd0, f_rd = 5'd0;
  logic [15:0] f_imm = 16'd0;
  logic [25:0] f_tgt = 26'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference encoder: fields shifted into place by plain arithmetic.
  function automatic logic [31:0] ref_enc(input int op, input logic [31:0] rs,
      input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] imm,
      input logic [31:0] tgt);
    int unsigned opc [16] = '{0, 0, 0, 0, 0, 35, 43, 4, 5, 8, 12, 2, 3, 0, 0, 0};
    int unsigned fn  [16] = '{32, 34, 36, 37, 42, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0};
    logic [31:0] o, f;
    o = opc[op];
    f = fn[op];
    if (op <= 4)  return (rs << 21) | (rt << 16) | (rd << 11) | f;
    if (op == 13) return (rs << 21) | f;
    if (op <= 10) return (o << 26) | (rs << 21) | (rt << 16) | imm;
    if (op <= 12) return (o << 26) | tgt;
    return 32'd0;
  endfunction

  // Monitor: compares the write port with the scoreboard head mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("wr_valid", bus.wr_valid_o, sb.size() > 0);
      chk("err", bus.err_o, err_m);
      chk("wr_count", bus.wr_count_o, cnt_m[15:0]);
      if (sb.size() > 0) begin
        chk("wr_addr", bus.wr_addr_o, sb[0].a);
        chk("wr_data", bus.wr_data_o, sb[0].d);
        if (bus.wr_ready_i && !bus.start_i) begin
          got.push_back(ent_t'({bus.wr_addr_o, bus.wr_data_o}));
          void'(sb.pop_front());
          cnt_m++;
        end
      end
    end
  end

  // One clock cycle: drive, check ready, advance the model past the edge.
  task automatic step(output bit acc);
    bit   exp_rdy;
    ent_t e;
    bus.start_i      = st;
    bus.req_valid_i  = v;
    bus.req_op_i     = f_op;
    bus.req_rs_i     = f_rs;
    bus.req_rt_i     = f_rt;
    bus.req_rd_i     = f_rd;
    bus.req_imm_i    = f_imm;
    bus.req_target_i = f_tgt;
    bus.wr_ready_i   = wrr;
    #1;
    exp_rdy = !st && (sb.size() < 2);
    chk("req_ready", bus.req_ready_o, exp_rdy);
    acc = v && exp_rdy;
    e.a = addr_m[AW-1:0];
    e.d = ref_enc(int'(f_op), 32'(f_rs), 32'(f_rt), 32'(f_rd), 32'(f_imm), 32'(f_tgt));
    @(posedge clk);
    #1;
    if (st) begin
      sb.delete();
      addr_m = BASE;
      err_m  = 1'b0;
    end else if (acc) begin
      if (f_op == 4'd15) begin
        err_m = 1'b1;
      end else begin
        sb.push_back(e);
        addr_m = (addr_m + 1) % (1 << AW);
      end
    end
  endtask

  task automatic idle(input int n);
    bit a;
    v = 1'b0;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    bit a = 1'b0;
    int k = 0;
    f_op = op; f_rs = rs; f_rt = rt; f_rd = rd; f_imm = imm; f_tgt = tgt;
    v = 1'b1;
    while (!a && k < 20) begin
      step(a);
      k++;
    end
    if (!a) begin
      total++; bad++;
      $display("FAIL send_timeout actual=%0d required=accept", k);
    end
  endtask

  task automatic pulse_start();
    bit a;
    v  = 1'b0;
    st = 1'b1;
    step(a);
    st = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    wrr = 1'b1;
    while (sb.size() > 0 && k < 20) begin
      idle(1);
      k++;
    end
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
    idle(1);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", bus.wr_valid_o, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    chk("rst_count", bus.wr_count_o, 16'd0);
    chk("rst_addr", bus.wr_addr_o, '0);
    chk("rst_data", bus.wr_data_o, 32'd0);
    chk("rst_ready", bus.req_ready_o, 1'b0);
    sb.delete();
    addr_m = BASE;
    err_m  = 1'b0;
    cnt_m  = 0;
    @(posedge clk);
    #1;
    chk("rst_ready_held", bus.req_ready_o, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    bit a;
    bus.start_i = 1'b0; bus.req_valid_i = 1'b0; bus.wr_ready_i = 1'b1;
    bus.req_op_i = 4'd14; bus.req_rs_i = 5'd0; bus.req_rt_i = 5'd0;
    bus.req_rd_i = 5'd0; bus.req_imm_i = 16'd0; bus.req_target_i = 26'd0;
    @(posedge clk);
    #1;
    do_reset();
    idle(1);

    // single ADD after reset
    got.delete();
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    drain();
    chk("add_word", got[0], {3'd0, 32'h00221820});
    chk("add_count", bus.wr_count_o, 16'd1);

    // back-to-back mixed formats
    pulse_start();
    got.delete();
    send(4'd5,  5'd29, 5'd8, 5'd0, 16'h0004, 26'd0);
    send(4'd7,  5'd4,  5'd5, 5'd0, 16'hFFFE, 26'd0);
    send(4'd12, 5'd0,  5'd0, 5'd0, 16'd0,    26'h10);
    send(4'd13, 5'd31, 5'd7, 5'd9, 16'd0,    26'd0);
    drain();
    chk("b2b_n", got.size(), 4);
    chk("b2b_lw",  got[0], {3'd0, 32'h8FA80004});
    chk("b2b_beq", got[1], {3'd1, 32'h1085FFFE});
    chk("b2b_jal", got[2], {3'd2, 32'h0C000010});
    chk("b2b_jr",  got[3], {3'd3, 32'h03E00008});

    // backpressure: two accepted, third stalls until memory drains
    pulse_start();
    got.delete();
    wrr = 1'b0;
    send(4'd9, 5'd1, 5'd2, 5'd0, 16'h0011, 26'd0);
    send(4'd10, 5'd3, 5'd4, 5'd0, 16'h0022, 26'd0);
    f_op = 4'd1; f_rs = 5'd5; f_rt = 5'd6; f_rd = 5'd7;
    for (int i = 0; i < 3; i++) step(a);
    wrr = 1'b1;
    send(4'd1, 5'd5, 5'd6, 5'd7, 16'd0, 26'd0);
    drain();
    chk("bp_n", got.size(), 3);
    chk("bp_a0", got[0].a, 3'd0);
    chk("bp_a1", got[1].a, 3'd1);
    chk("bp_a2", got[2].a, 3'd2);

    // address wrap
    pulse_start();
    got.delete();
    for (int i = 0; i < 9; i++) send(4'd14, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    drain();
    chk("wrap_a7", got[7].a, 3'd7);
    chk("wrap_a8", got[8].a, 3'd0);

    // illegal op then ADD
    pulse_start();
    got.delete();
    send(4'd15, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0);
    chk("ill_err", bus.err_o, 1'b1);
    chk("ill_novalid", bus.wr_valid_o, 1'b0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    drain();
    chk("ill_add_addr", got[0].a, 3'd0);
    pulse_start();
    chk("start_err_clr", bus.err_o, 1'b0);
    got.delete();
    send(4'd3, 5'd2, 5'd2, 5'd2, 16'd0, 26'd0);
    drain();
    chk("start_rewind", got[0].a, 3'd0);

    // reset with two words buffered
    wrr = 1'b0;
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    send(4'd4, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
    idle(1);
    do_reset();
    wrr = 1'b1;
    idle(1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      st    = ($urandom_range(0, 49) == 0);
      v     = ($urandom_range(0, 3) != 0);
      wrr   = ($urandom_range(0, 3) != 0);
      f_op  = 4'($urandom_range(0, 15));
      f_rs  = 5'($urandom);
      f_rt  = 5'($urandom);
      f_rd  = 5'($urandom);
      f_imm = 16'($urandom);
      f_tgt = 26'($urandom);
      if (i == 400) begin
        do_reset();
      end
      step(a);
    end
    st = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
